// File: rtl/soc_gpio_reg_bank.sv
// soc_gpio_reg_bank
// 32-bit memory-mapped GPIO register bank. It provides:
//   - output data and direction registers
//   - a two-flop input synchronizer
//   - atomic set/clear/toggle access to the output data
//   - rising-edge status with per-bit interrupt enables
// Only bus_addr[4:2] is decoded, so the eight registers alias across the window.
module soc_gpio_reg_bank (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bus_valid,
   input  logic        bus_we,
   input  logic [31:0] bus_addr,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   input  logic [31:0] gpio_in,
   output logic [31:0] gpio_out,
   output logic [31:0] gpio_oe,
   output logic        irq
);

   localparam logic [2:0] OFF_DATA_OUT  = 3'd0;
   localparam logic [2:0] OFF_DIR       = 3'd1;
   localparam logic [2:0] OFF_DATA_IN   = 3'd2;
   localparam logic [2:0] OFF_SET       = 3'd3;
   localparam logic [2:0] OFF_CLR       = 3'd4;
   localparam logic [2:0] OFF_TOGGLE    = 3'd5;
   localparam logic [2:0] OFF_EDGE_STAT = 3'd6;
   localparam logic [2:0] OFF_IRQ_EN    = 3'd7;

   // Architectural state
   logic [31:0] data_out_r;
   logic [31:0] dir_r;
   logic [31:0] edge_stat_r;
   logic [31:0] irq_en_r;
   logic [31:0] rdata_r;

   // Input path: sync1_r is the metastability flop, sync2_r is DATA_IN
   logic [31:0] sync1_r;
   logic [31:0] sync2_r;
   logic [31:0] prev_r;

   // Next-state and decode signals
   logic        wr_s;
   logic        rd_s;
   logic [2:0]  sel_s;
   logic [31:0] rise_s;
   logic [31:0] data_out_nxt_s;
   logic [31:0] dir_nxt_s;
   logic [31:0] edge_stat_nxt_s;
   logic [31:0] irq_en_nxt_s;
   logic [31:0] rdata_nxt_s;

   assign wr_s   = bus_valid & bus_we;
   assign rd_s   = bus_valid & ~bus_we;
   assign sel_s  = bus_addr[4:2];
   assign rise_s = sync2_r & ~prev_r;

   // Write decode: at most one register changes per cycle; a new rise always wins over W1C
   always_comb begin
      data_out_nxt_s  = data_out_r;
      dir_nxt_s       = dir_r;
      irq_en_nxt_s    = irq_en_r;
      edge_stat_nxt_s = edge_stat_r;
      if (wr_s) begin
         case (sel_s)
            OFF_DATA_OUT:  data_out_nxt_s  = bus_wdata;
            OFF_DIR:       dir_nxt_s       = bus_wdata;
            OFF_DATA_IN:   data_out_nxt_s  = data_out_r;
            OFF_SET:       data_out_nxt_s  = data_out_r | bus_wdata;
            OFF_CLR:       data_out_nxt_s  = data_out_r & ~bus_wdata;
            OFF_TOGGLE:    data_out_nxt_s  = data_out_r ^ bus_wdata;
            OFF_EDGE_STAT: edge_stat_nxt_s = edge_stat_r & ~bus_wdata;
            OFF_IRQ_EN:    irq_en_nxt_s    = bus_wdata;
            default:       data_out_nxt_s  = data_out_r;
         endcase
      end else begin
         data_out_nxt_s = data_out_r;
      end
      edge_stat_nxt_s = edge_stat_nxt_s | rise_s;
   end

   // Read mux: write-only registers read as zero
   always_comb begin
      rdata_nxt_s = rdata_r;
      if (rd_s) begin
         case (sel_s)
            OFF_DATA_OUT:  rdata_nxt_s = data_out_r;
            OFF_DIR:       rdata_nxt_s = dir_r;
            OFF_DATA_IN:   rdata_nxt_s = sync2_r;
            OFF_SET:       rdata_nxt_s = 32'h0000_0000;
            OFF_CLR:       rdata_nxt_s = 32'h0000_0000;
            OFF_TOGGLE:    rdata_nxt_s = 32'h0000_0000;
            OFF_EDGE_STAT: rdata_nxt_s = edge_stat_r;
            OFF_IRQ_EN:    rdata_nxt_s = irq_en_r;
            default:       rdata_nxt_s = 32'h0000_0000;
         endcase
      end else begin
         rdata_nxt_s = rdata_r;
      end
   end

   // Register bank and read data capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out_r  <= 32'h0000_0000;
         dir_r       <= 32'h0000_0000;
         edge_stat_r <= 32'h0000_0000;
         irq_en_r    <= 32'h0000_0000;
         rdata_r     <= 32'h0000_0000;
      end else begin
         data_out_r  <= data_out_nxt_s;
         dir_r       <= dir_nxt_s;
         edge_stat_r <= edge_stat_nxt_s;
         irq_en_r    <= irq_en_nxt_s;
         rdata_r     <= rdata_nxt_s;
      end
   end

   // Input synchronizer and previous-value flop for rising-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 32'h0000_0000;
         sync2_r <= 32'h0000_0000;
         prev_r  <= 32'h0000_0000;
      end else begin
         sync1_r <= gpio_in;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
      end
   end

   assign gpio_out  = data_out_r;
   assign gpio_oe   = dir_r;
   assign bus_rdata = rdata_r;
   assign irq       = |(edge_stat_r & irq_en_r);

endmodule

// File: tb/tb_soc_gpio_reg_bank.sv
// Testbench for soc_gpio_reg_bank.
// A vector table covers the register map; hand-written sequences cover
// held writes, input edge timing and asynchronous reset.
module tb_soc_gpio_reg_bank;

   logic        clk;
   logic        rst_n;
   logic        bus_valid;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic [31:0] gpio_in;
   logic [31:0] gpio_out;
   logic [31:0] gpio_oe;
   logic        irq;

   int n_checks;
   int n_errors;

   typedef struct {
      logic        valid;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic [31:0] exp_out;
      logic [31:0] exp_oe;
   } vec_t;

   localparam int NVEC = 24;
   vec_t vecs [NVEC];

   soc_gpio_reg_bank dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus_valid (bus_valid),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .gpio_in   (gpio_in),
      .gpio_out  (gpio_out),
      .gpio_oe   (gpio_oe),
      .irq       (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One bus cycle: drive inputs, step through the rising edge, return 1 time unit later
   task automatic cyc(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
      bus_valid = v;
      bus_we    = w;
      bus_addr  = a;
      bus_wdata = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;

      //            valid we    addr          wdata         chk   exp_rd        exp_out       exp_oe
      vecs[0]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h0000_001F, 1'b0, 32'h0,        32'h0000_001F, 32'h0};
      vecs[1]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,        1'b1, 32'h0000_001F, 32'h0000_001F, 32'h0};
      vecs[2]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,        1'b1, 32'h0000_001F, 32'h0000_001F, 32'h0};
      vecs[3]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h0000_000F, 1'b0, 32'h0,        32'h0000_000F, 32'h0};
      vecs[4]  = '{1'b1, 1'b1, 32'h0000_000C, 32'h0000_00F0, 1'b0, 32'h0,        32'h0000_00FF, 32'h0};
      vecs[5]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,        1'b1, 32'h0000_00FF, 32'h0000_00FF, 32'h0};
      vecs[6]  = '{1'b1, 1'b1, 32'h0000_0010, 32'h0000_0003, 1'b0, 32'h0,        32'h0000_00FC, 32'h0};
      vecs[7]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,        1'b1, 32'h0000_00FC, 32'h0000_00FC, 32'h0};
      vecs[8]  = '{1'b1, 1'b1, 32'h0000_0014, 32'h0000_0101, 1'b0, 32'h0,        32'h0000_01FD, 32'h0};
      vecs[9]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,        1'b1, 32'h0000_01FD, 32'h0000_01FD, 32'h0};
      vecs[10] = '{1'b1, 1'b0, 32'h0000_000C, 32'h0,        1'b1, 32'h0000_0000, 32'h0000_01FD, 32'h0};
      vecs[11] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        1'b1, 32'h0000_0000, 32'h0000_01FD, 32'h0};
      vecs[12] = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,        1'b1, 32'h0000_0000, 32'h0000_01FD, 32'h0};
      vecs[13] = '{1'b1, 1'b1, 32'h0000_0004, 32'h1234_5678, 1'b0, 32'h0,        32'h0000_01FD, 32'h1234_5678};
      vecs[14] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,        1'b1, 32'h1234_5678, 32'h0000_01FD, 32'h1234_5678};
      vecs[15] = '{1'b1, 1'b1, 32'h0000_0008, 32'h0000_FFFF, 1'b0, 32'h0,        32'h0000_01FD, 32'h1234_5678};
      vecs[16] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,        1'b1, 32'h0000_0000, 32'h0000_01FD, 32'h1234_5678};
      vecs[17] = '{1'b1, 1'b1, 32'h0000_0000, 32'h0000_00A5, 1'b0, 32'h0,        32'h0000_00A5, 32'h1234_5678};
      vecs[18] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,        1'b1, 32'h0000_00A5, 32'h0000_00A5, 32'h1234_5678};
      vecs[19] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,        1'b1, 32'h0000_00A5, 32'h0000_00A5, 32'h1234_5678};
      vecs[20] = '{1'b1, 1'b1, 32'h0000_001C, 32'h0000_0003, 1'b0, 32'h0,        32'h0000_00A5, 32'h1234_5678};
      vecs[21] = '{1'b1, 1'b0, 32'h0000_001C, 32'h0,        1'b1, 32'h0000_0003, 32'h0000_00A5, 32'h1234_5678};
      vecs[22] = '{1'b1, 1'b1, 32'h0000_001C, 32'h0000_0000, 1'b0, 32'h0,        32'h0000_00A5, 32'h1234_5678};
      vecs[23] = '{1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0003, 32'h0000_00A5, 32'h1234_5678};

      rst_n     = 1'b0;
      bus_valid = 1'b0;
      bus_we    = 1'b0;
      bus_addr  = 32'h0;
      bus_wdata = 32'h0;
      gpio_in   = 32'h0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_gpio_out", gpio_out, 32'h0);
      chk("reset_gpio_oe", gpio_oe, 32'h0);
      chk("reset_irq", {31'h0, irq}, 32'h0);
      chk("reset_rdata", bus_rdata, 32'h0);

      // Table-driven register map vectors
      for (int i = 0; i < NVEC; i++) begin
         cyc(vecs[i].valid, vecs[i].we, vecs[i].addr, vecs[i].wdata);
         chk($sformatf("vec%0d_out", i), gpio_out, vecs[i].exp_out);
         chk($sformatf("vec%0d_oe", i), gpio_oe, vecs[i].exp_oe);
         chk($sformatf("vec%0d_irq", i), {31'h0, irq}, 32'h0);
         if (vecs[i].chk_rd) begin
            chk($sformatf("vec%0d_rdata", i), bus_rdata, vecs[i].exp_rd);
         end
      end

      // Held bus_valid for 3 cycles, bus_we only in the first: toggle applies once
      cyc(1'b1, 1'b1, 32'h0000_0014, 32'h0000_0001);
      chk("held_tog_c1", gpio_out, 32'h0000_00A4);
      cyc(1'b1, 1'b0, 32'h0000_0014, 32'h0000_0001);
      chk("held_tog_c2", gpio_out, 32'h0000_00A4);
      cyc(1'b1, 1'b0, 32'h0000_0014, 32'h0000_0001);
      chk("held_tog_c3", gpio_out, 32'h0000_00A4);
      chk("held_tog_rd", bus_rdata, 32'h0);

      // Input synchronization and edge detection
      gpio_in = 32'h8000_0001;
      cyc(1'b1, 1'b0, 32'h0000_0008, 32'h0);
      chk("sync_e1_rd", bus_rdata, 32'h0);
      cyc(1'b1, 1'b0, 32'h0000_0008, 32'h0);
      chk("sync_e2_rd", bus_rdata, 32'h0);
      cyc(1'b1, 1'b0, 32'h0000_0008, 32'h0);
      chk("sync_e3_datain", bus_rdata, 32'h8000_0001);
      chk("sync_e3_irq_masked", {31'h0, irq}, 32'h0);
      cyc(1'b1, 1'b0, 32'h0000_0018, 32'h0);
      chk("edge_stat", bus_rdata, 32'h8000_0001);
      chk("edge_irq_masked", {31'h0, irq}, 32'h0);
      cyc(1'b1, 1'b1, 32'h0000_001C, 32'h0000_0001);
      chk("irq_en_set", {31'h0, irq}, 32'h1);
      cyc(1'b1, 1'b1, 32'h0000_0018, 32'h0000_0001);
      chk("w1c_irq", {31'h0, irq}, 32'h0);
      cyc(1'b1, 1'b0, 32'h0000_0018, 32'h0);
      chk("w1c_stat", bus_rdata, 32'h8000_0000);

      // W1C of bit 2 in the same cycle its rise is detected: set wins
      cyc(1'b1, 1'b1, 32'h0000_001C, 32'h0000_0004);
      gpio_in = 32'h8000_0005;
      cyc(1'b0, 1'b0, 32'h0, 32'h0);
      chk("simul_e1_irq", {31'h0, irq}, 32'h0);
      cyc(1'b0, 1'b0, 32'h0, 32'h0);
      chk("simul_e2_irq", {31'h0, irq}, 32'h0);
      cyc(1'b1, 1'b1, 32'h0000_0018, 32'h0000_0004);
      chk("simul_e3_irq", {31'h0, irq}, 32'h1);
      cyc(1'b1, 1'b0, 32'h0000_0018, 32'h0);
      chk("simul_stat", bus_rdata, 32'h8000_0004);
      cyc(1'b1, 1'b1, 32'h0000_0018, 32'h0000_0004);
      chk("simul_clear_irq", {31'h0, irq}, 32'h0);
      cyc(1'b1, 1'b0, 32'h0000_0018, 32'h0);
      chk("simul_clear_stat", bus_rdata, 32'h8000_0000);

      // Asynchronous reset between edges
      cyc(1'b1, 1'b1, 32'h0000_0000, 32'h0000_00A5);
      cyc(1'b1, 1'b1, 32'h0000_0004, 32'h0000_00FF);
      cyc(1'b1, 1'b0, 32'h0000_0000, 32'h0);
      chk("prerst_out", gpio_out, 32'h0000_00A5);
      chk("prerst_oe", gpio_oe, 32'h0000_00FF);
      chk("prerst_rd", bus_rdata, 32'h0000_00A5);
      bus_valid = 1'b0;
      bus_we    = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_out", gpio_out, 32'h0);
      chk("arst_oe", gpio_oe, 32'h0);
      chk("arst_rd", bus_rdata, 32'h0);
      chk("arst_irq", {31'h0, irq}, 32'h0);
      #1;
      rst_n = 1'b1;
      cyc(1'b0, 1'b0, 32'h0, 32'h0);
      chk("postrst_out", gpio_out, 32'h0);
      chk("postrst_oe", gpio_oe, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
